// File: rtl/add_round_key_stage.sv
// rtl/add_round_key_stage.sv - registered AES AddRoundKey stage with round tracking and skid buffer
module add_round_key_stage #(
  parameter int BLOCK_LENGTH = 128,
  parameter int NR           = 10
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [BLOCK_LENGTH-1:0] sr_in_i,
  input  logic [BLOCK_LENGTH-1:0] mc_in_i,
  input  logic [BLOCK_LENGTH-1:0] round_key_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [BLOCK_LENGTH-1:0] out_o,
  output logic [3:0]              round_o,
  output logic                    last_o
);

  // The round tag is 4 bits wide, so the final round index must fit in it.
  localparam logic [3:0] NR_L = 4'(NR);

  // Round counter: index the next accepted beat will carry unless START overrides it.
  logic [3:0]              rnd_q, rnd_d;

  // Output register: the beat currently presented downstream.
  logic                    out_valid_q, out_valid_d;
  logic [BLOCK_LENGTH-1:0] out_data_q, out_data_d;
  logic [3:0]              out_round_q, out_round_d;
  logic                    out_last_q, out_last_d;

  // Skid register: catches one beat accepted while the output register is stalled.
  logic                    skid_full_q, skid_full_d;
  logic [BLOCK_LENGTH-1:0] skid_data_q, skid_data_d;
  logic [3:0]              skid_round_q, skid_round_d;
  logic                    skid_last_q, skid_last_d;

  // Registered ready, kept equal to the inverse of the next skid occupancy.
  logic                    in_ready_q, in_ready_d;

  // Beat being formed from the current input.
  logic [3:0]              r_eff;
  logic                    sel_mc;
  logic [BLOCK_LENGTH-1:0] beat_data;
  logic                    beat_last;
  logic                    accept;
  logic                    out_free;

  // Decode the effective round and form the keyed beat for this cycle's input.
  always_comb begin
    r_eff     = start_i ? 4'd0 : rnd_q;
    sel_mc    = (r_eff != 4'd0) && (r_eff != NR_L);
    beat_data = (sel_mc ? mc_in_i : sr_in_i) ^ round_key_i;
    beat_last = (r_eff == NR_L);
    accept    = in_valid_i & in_ready_q;
    // The output register can take a new beat when it is empty or being drained this cycle.
    out_free  = ~out_valid_q | out_ready_i;
  end

  // Next-state for the round counter: advance on every accept, wrap after the final round.
  always_comb begin
    rnd_d = rnd_q;
    if (accept) begin
      rnd_d = beat_last ? 4'd0 : (r_eff + 4'd1);
    end
  end

  // Next-state for output and skid registers; the skid always holds the younger beat.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_round_d  = out_round_q;
    out_last_d   = out_last_q;
    skid_full_d  = skid_full_q;
    skid_data_d  = skid_data_q;
    skid_round_d = skid_round_q;
    skid_last_d  = skid_last_q;

    if (out_free) begin
      if (skid_full_q) begin
        // Older skid beat moves forward; no accept is possible while the skid is full.
        out_valid_d = 1'b1;
        out_data_d  = skid_data_q;
        out_round_d = skid_round_q;
        out_last_d  = skid_last_q;
        skid_full_d = 1'b0;
      end else if (accept) begin
        // Empty skid: the new beat goes straight into the output register.
        out_valid_d = 1'b1;
        out_data_d  = beat_data;
        out_round_d = r_eff;
        out_last_d  = beat_last;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      // Output stalled with a pending beat: park the new one in the skid.
      skid_full_d  = 1'b1;
      skid_data_d  = beat_data;
      skid_round_d = r_eff;
      skid_last_d  = beat_last;
    end

    in_ready_d = ~skid_full_d;
  end

  // State registers; reset discards any in-flight beats and restarts the round count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rnd_q        <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_round_q  <= '0;
      out_last_q   <= 1'b0;
      skid_full_q  <= 1'b0;
      skid_data_q  <= '0;
      skid_round_q <= '0;
      skid_last_q  <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      rnd_q        <= rnd_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_round_q  <= out_round_d;
      out_last_q   <= out_last_d;
      skid_full_q  <= skid_full_d;
      skid_data_q  <= skid_data_d;
      skid_round_q <= skid_round_d;
      skid_last_q  <= skid_last_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_o       = out_data_q;
  assign round_o     = out_round_q;
  assign last_o      = out_last_q;

endmodule

// File: tb/tb_add_round_key_stage.sv
// tb/tb_add_round_key_stage.sv - randomized scoreboard bench for add_round_key_stage (NR=10 and NR=14)
module tb_add_round_key_stage;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [127:0] sr_in = '0;
  logic [127:0] mc_in = '0;
  logic [127:0] key = '0;

  logic         in_ready10, in_ready14;
  logic         out_valid10, out_valid14;
  logic [127:0] out10, out14;
  logic [3:0]   round10, round14;
  logic         last10, last14;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [127:0] data;
    logic [3:0]   round;
    logic         last;
  } beat_t;

  beat_t exp_q [2][$];
  int    rnd_m [2];

  always #5 clk = ~clk;

  add_round_key_stage #(.BLOCK_LENGTH(128), .NR(10)) u_dut10 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .in_valid_i(in_valid),
    .in_ready_o(in_ready10), .sr_in_i(sr_in), .mc_in_i(mc_in), .round_key_i(key),
    .out_valid_o(out_valid10), .out_ready_i(out_ready), .out_o(out10),
    .round_o(round10), .last_o(last10)
  );

  add_round_key_stage #(.BLOCK_LENGTH(128), .NR(14)) u_dut14 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .in_valid_i(in_valid),
    .in_ready_o(in_ready14), .sr_in_i(sr_in), .mc_in_i(mc_in), .round_key_i(key),
    .out_valid_o(out_valid14), .out_ready_i(out_ready), .out_o(out14),
    .round_o(round14), .last_o(last14)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference: a FIFO of at most two beats per instance, each beat built from the round rule.
  always @(negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      exp_q[k].delete();
      rnd_m[k] = 0;
    end
  end

  always @(posedge clk) begin : model
    int    nr;
    int    r;
    bit    acc;
    beat_t b;
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        nr  = (k == 0) ? 10 : 14;
        acc = in_valid && (exp_q[k].size() < 2);
        if (exp_q[k].size() > 0 && out_ready) void'(exp_q[k].pop_front());
        if (acc) begin
          r       = start ? 0 : rnd_m[k];
          b.data  = ((r == 0 || r == nr) ? sr_in : mc_in) ^ key;
          b.round = 4'(r);
          b.last  = (r == nr);
          exp_q[k].push_back(b);
          rnd_m[k] = (r == nr) ? 0 : r + 1;
        end
      end
    end
  end

  // Every negedge: handshake outputs and the head beat must match the reference.
  always @(negedge clk) begin
    check("valid10", {127'd0, out_valid10}, {127'd0, exp_q[0].size() > 0});
    check("ready10", {127'd0, in_ready10}, {127'd0, exp_q[0].size() < 2});
    check("valid14", {127'd0, out_valid14}, {127'd0, exp_q[1].size() > 0});
    check("ready14", {127'd0, in_ready14}, {127'd0, exp_q[1].size() < 2});
    if (exp_q[0].size() > 0) begin
      check("data10", out10, exp_q[0][0].data);
      check("round10", {124'd0, round10}, {124'd0, exp_q[0][0].round});
      check("last10", {127'd0, last10}, {127'd0, exp_q[0][0].last});
    end
    if (exp_q[1].size() > 0) begin
      check("data14", out14, exp_q[1][0].data);
      check("round14", {124'd0, round14}, {124'd0, exp_q[1][0].round});
      check("last14", {127'd0, last14}, {127'd0, exp_q[1][0].last});
    end
  end

  // Offer one beat at a negedge; returns at the next negedge with inputs idle.
  task automatic send(input logic s, input logic [127:0] sr, input logic [127:0] mc,
                      input logic [127:0] k);
    start    = s;
    in_valid = 1'b1;
    sr_in    = sr;
    mc_in    = mc;
    key      = k;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    logic [127:0] r128;
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("rst_valid", {127'd0, out_valid10}, 128'd0);
    check("rst_ready", {127'd0, in_ready10}, 128'd1);
    check("rst_out", out10, 128'd0);
    check("rst_round", {124'd0, round10}, 128'd0);
    check("rst_last", {127'd0, last10}, 128'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // FIPS-197 App.B round 0 and round 1.
    out_ready = 1'b1;
    send(1'b1, 128'h3243f6a8885a308d313198a2e0370734, rand128(),
         128'h2b7e151628aed2a6abf7158809cf4f3c);
    check("t1_out", out10, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
    check("t1_round", {124'd0, round10}, 128'd0);
    check("t1_last", {127'd0, last10}, 128'd0);
    send(1'b0, rand128(), 128'h046681e5e0cb199a48f8d37a2806264c,
         128'ha0fafe1788542cb123a339392a6c7605);
    check("t2_out", out10, 128'ha49c7ff2689f352b6b5bea43026a5049);
    check("t2_round", {124'd0, round10}, 128'd1);

    // Full block, key zero, MC = SR ^ 1.
    for (int i = 0; i <= 10; i++) begin
      r128 = rand128();
      send(i == 0, r128, r128 ^ 128'd1, 128'd0);
      check("t3_out", out10, (i == 0 || i == 10) ? r128 : (r128 ^ 128'd1));
      check("t3_last", {127'd0, last10}, {127'd0, i == 10});
    end
    send(1'b0, rand128(), rand128(), rand128());
    check("t3_wrap", {124'd0, round10}, 128'd0);

    // Backpressure: three beats offered with the output stalled.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    sr_in = rand128(); mc_in = rand128(); key = rand128();
    @(negedge clk);
    sr_in = rand128(); mc_in = rand128(); key = rand128();
    @(negedge clk);
    check("t4_full", {127'd0, in_ready10}, 128'd0);
    sr_in = rand128(); mc_in = rand128(); key = rand128();
    @(negedge clk);
    check("t4_hold", {127'd0, in_ready10}, 128'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 4 && in_valid; i++) begin
      @(negedge clk);
      if (in_ready10 && i > 0) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    repeat (3) @(negedge clk);

    // START mid-block at round 5.
    for (int i = 0; i < 5; i++) send(i == 0, rand128(), rand128(), rand128());
    check("t5_pre", {124'd0, round10}, 128'd4);
    send(1'b1, rand128(), rand128(), rand128());
    check("t5_restart", {124'd0, round10}, 128'd0);
    send(1'b0, rand128(), rand128(), rand128());
    check("t5_next", {124'd0, round10}, 128'd1);

    // NR=14 block.
    for (int i = 0; i <= 14; i++) begin
      send(i == 0, rand128(), rand128(), rand128());
      check("t5_last14", {127'd0, last14}, {127'd0, i == 14});
    end

    // Reset mid-block with both entries full.
    out_ready = 1'b0;
    send(1'b1, rand128(), rand128(), rand128());
    send(1'b0, rand128(), rand128(), rand128());
    check("t6_full", {127'd0, in_ready10}, 128'd0);
    #2 rst_n = 1'b0;
    #1;
    check("t6_valid", {127'd0, out_valid10}, 128'd0);
    check("t6_ready", {127'd0, in_ready10}, 128'd1);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(1'b0, rand128(), rand128(), rand128());
    check("t6_round", {124'd0, round10}, 128'd0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      start     = ($urandom_range(0, 24) == 0);
      sr_in = rand128(); mc_in = rand128(); key = rand128();
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
